// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused over WIDTH clocks, LSB first,
// with a carry flop closing the loop and a start/busy/done handshake.

module FA (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);
    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic             carry_q, carry_d, co_q, co_d, busy_q, done_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_sum, fa_co;
    logic [WIDTH-1:0] res_shift;

    FA u_fa (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .ci  (carry_q),
        .sum (fa_sum),
        .co  (fa_co)
    );

    // New sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_res_1
            assign res_shift = fa_sum;
        end else begin : g_res_n
            assign res_shift = {fa_sum, res_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        co_d    = co_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_shift;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_shift;
                    co_d    = fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Accepting start here gives back-to-back operation without an IDLE cycle.
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign co   = co_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for directed and random
// operations, and a 4-bit instance swept over every (a, b, ci) combination.

module tb_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, ci8, busy8, done8, co8;
    logic [7:0] a8, b8, sum8;
    logic       start4, ci4, busy4, done4, co4;
    logic [3:0] a4, b4, sum4;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .co(co8)
    );
    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .ci(ci4),
        .busy(busy4), .done(done4), .sum(sum4), .co(co4)
    );

    typedef struct {
        logic [32:0] v;
        int          k;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        c;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   rst_edge = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_edge = rst;
    end

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=no-event (cycle %0d)", name, cyc);
    endtask

    // ---------------- monitors ----------------
    logic [8:0] prev8;
    logic [4:0] prev4;
    int         bcnt8 = 0, bcnt4 = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_edge) bcnt8 = 0;
        else if (busy8) bcnt8++;
        else if (bcnt8 != 0) begin
            chk("busy_len8", 33'(bcnt8), 33'd8);
            bcnt8 = 0;
        end
        if (busy8 || done8) chk("busy_done_excl8", 33'(busy8 & done8), 33'd0);
        if (!done8 && !rst_edge) chk("sum_hold8", {24'd0, co8, sum8}, {24'd0, prev8});
        if (done8) begin
            if (q8.size() == 0) fail_now("unexpected_done8");
            else begin
                e = q8.pop_front();
                chk("result8", {24'd0, co8, sum8}, e.v);
                chk("latency8", 33'(cyc - e.k), 33'd8);
                $display("dut8 a=%02h b=%02h ci=%0d -> co=%0d sum=%02h", e.a, e.b, e.c, co8, sum8);
            end
        end
        prev8 = {co8, sum8};
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_edge) bcnt4 = 0;
        else if (busy4) bcnt4++;
        else if (bcnt4 != 0) begin
            chk("busy_len4", 33'(bcnt4), 33'd4);
            bcnt4 = 0;
        end
        if (busy4 || done4) chk("busy_done_excl4", 33'(busy4 & done4), 33'd0);
        if (!done4 && !rst_edge) chk("sum_hold4", {28'd0, co4, sum4}, {28'd0, prev4});
        if (done4) begin
            if (q4.size() == 0) fail_now("unexpected_done4");
            else begin
                e = q4.pop_front();
                chk("result4", {28'd0, co4, sum4}, e.v);
                chk("latency4", 33'(cyc - e.k), 33'd4);
                $display("dut4 a=%01h b=%01h ci=%0d -> co=%0d sum=%01h", e.a[3:0], e.b[3:0], e.c, co4, sum4);
            end
        end
        prev4 = {co4, sum4};
    end

    // ---------------- drivers (called at a negedge, DUT not busy) ----------------
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        exp_t e;
        start8 = 1'b1; a8 = a; b8 = b; ci8 = c;
        e.v = 33'(a) + 33'(b) + 33'(c);
        e.k = cyc + 1;
        e.a = a; e.b = b; e.c = c;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c);
        exp_t e;
        start4 = 1'b1; a4 = a; b4 = b; ci4 = c;
        e.v = 33'(a) + 33'(b) + 33'(c);
        e.k = cyc + 1;
        e.a = {4'd0, a}; e.b = {4'd0, b}; e.c = c;
        q4.push_back(e);
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
    endtask

    task automatic wait_done8();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done8) break;
        end
        if (!done8) fail_now("done_timeout8");
    endtask

    task automatic wait_done4();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done4) break;
        end
        if (!done4) fail_now("done_timeout4");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 33'(busy8), 33'd0);
        chk("reset_done", 33'(done8), 33'd0);
        chk("reset_result", {24'd0, co8, sum8}, 33'd0);
        chk("reset_result4", {28'd0, co4, sum4}, 33'd0);
        rst = 1'b0;
        @(negedge clk);

        // zero operands, full carry ripple
        issue8(8'h00, 8'h00, 1'b0); wait_done8();
        @(negedge clk);
        issue8(8'hFF, 8'h01, 1'b0); wait_done8();
        @(negedge clk);
        issue8(8'hA5, 8'h5A, 1'b1); wait_done8();
        @(negedge clk);

        // start pulse and operand changes during RUN must be ignored
        issue8(8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hC3; ci8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; b8 = 8'h3C; ci8 = 1'b0;
        wait_done8();
        repeat (4) @(negedge clk);

        // back-to-back with start held through RUN
        issue8(8'h37, 8'h21, 1'b0);
        start8 = 1'b1;
        wait_done8();
        issue8(8'h80, 8'h80, 1'b0);
        chk("b2b_busy", 33'(busy8), 33'd1);
        wait_done8();
        @(negedge clk);

        // reset at the 4th RUN edge aborts the operation
        issue8(8'h0F, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q8.delete();
        @(negedge clk);
        chk("abort_busy", 33'(busy8), 33'd0);
        chk("abort_done", 33'(done8), 33'd0);
        chk("abort_result", {24'd0, co8, sum8}, 33'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue8(8'h0F, 8'h01, 1'b0); wait_done8();

        // reset and start together: reset wins
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; rst = 1'b1;
        @(negedge clk);
        start8 = 1'b0; rst = 1'b0;
        chk("rst_start_busy", 33'(busy8), 33'd0);
        repeat (12) @(negedge clk);

        // random operations with random gaps (gap 0 = back-to-back)
        for (int i = 0; i < 40; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
            wait_done8();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        @(negedge clk);

        // exhaustive 4-bit sweep, back-to-back
        for (int i = 0; i < 512; i++) begin
            issue4(4'(i), 4'(i >> 4), 1'(i >> 8));
            wait_done4();
        end

        repeat (10) @(negedge clk);
        chk("q8_drained", 33'(q8.size()), 33'd0);
        chk("q4_drained", 33'(q4.size()), 33'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

- Bit-serial adder for two WIDTH-bit operands plus carry-in.
- Instantiates one `FA` cell and feeds its carry-out back to its carry-in through a carry flip-flop, so one bit is added per clock, LSB first.
- Sits directly downstream of `FA`: it consumes `sum`/`co` each cycle and registers them into a result shift register and carry register.
- Start/busy/done handshake lets a controller launch an addition and collect a registered result.

## Interface
- WIDTH, default 8, operand and result width in bits (legal range 1..32).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepted-start edge.
- b  input  WIDTH  operand B; captured on the accepted-start edge.
- ci  input  1  carry-in; captured on the accepted-start edge.
- busy  output  1  high while bits are being added (RUN state).
- done  output  1  one-cycle pulse; sum/co are valid and new.
- sum  output  WIDTH  registered result, held until the next done.
- co  output  1  registered final carry-out, held with sum.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset** (rst=1 at an edge) has priority over everything.
  - Next state is IDLE.
  - busy=0, done=0, sum=0, co=0.
  - Internal operand, carry and bit-counter registers are cleared.
- **IDLE**
  - start=1: capture a, b, ci into the A shift register, B shift register and carry flop; clear the bit counter; go to RUN.
  - start=0: stay in IDLE.
- **RUN**
  - `FA` inputs are the A register's bit 0, the B register's bit 0, and the carry flop.
  - Every edge:
    - A and B shift right by one.
    - `FA` `sum` shifts into the MSB of the internal result register, which also shifts right.
    - `FA` `co` loads the carry flop.
    - The counter increments.
  - On the edge where the counter reaches WIDTH-1 (the WIDTH-th RUN edge):
    - Copy the completed result into `sum` and the `FA` `co` into `co`.
    - Go to DONE.
  - start is ignored in RUN.
- **DONE**
  - done=1 for exactly this one cycle.
  - If start=1: capture new operands and go straight to RUN (back-to-back operation, no IDLE gap).
  - Otherwise: go to IDLE.
- **Output stability:** `sum`/`co` change only on the edge entering DONE or on reset. They stay stable through later RUN phases.
- **Arithmetic:** {co, sum} = a + b + ci, evaluated at full WIDTH+1 bits with no truncation. The counter is wide enough to hold WIDTH-1.
- **Input sampling:** a, b, ci are sampled only on the accepted-start edge. Changes at any other time have no effect.

## Timing
- Accepted start at edge k:
  - busy=1 from edge k to edge k+WIDTH.
  - busy=0 and done=1 in the cycle after edge k+WIDTH.
  - done falls at edge k+WIDTH+1.
- Latency from start sample to done: WIDTH+1 edges.
- Throughput: one result per WIDTH+1 cycles, with start held or re-asserted in DONE.
- Outputs in relation to each other:
  - done and busy are never high together.
  - busy is the registered RUN-state decode.
  - done is the registered DONE-state decode.
- Reset asserted mid-RUN:
  - The operation aborts.
  - done never pulses for it.
  - sum/co clear to 0 at that edge.
- Reset and start both high at the same edge: reset wins and the block stays in IDLE.

## Test plan
1. **Reset values, zero operands.** rst for 2 cycles, then start with a=8'h00, b=8'h00, ci=0. Required: after reset, busy=0, done=0, sum=0, co=0. done pulses exactly 9 edges after the start edge, with sum=8'h00, co=0.
2. **Full carry ripple.** a=8'hFF, b=8'h01, ci=0, then a=8'hA5, b=8'h5A, ci=1. Required: both give sum=8'h00, co=1, and busy is high for exactly 8 cycles each time.
3. **Input isolation.** Start a=8'h12, b=8'h34, ci=0. During RUN, pulse start with a=8'hFF and toggle b/ci. Required: result is sum=8'h46, co=0; exactly one done pulse; no second operation is launched.
4. **Back-to-back operation.** Hold start=1 continuously. Present a=8'h80, b=8'h80, ci=0 in the DONE cycle of the previous operation. Required: busy rises the edge after done, and the next done shows sum=8'h00, co=1. The previous sum stays stable until that done.
5. **Reset mid-operation.** Assert rst at the 4th RUN edge of a=8'h0F + b=8'h01. Required: busy=0, done never pulses, sum=0, co=0. A following start with a=8'h0F, b=8'h01 returns sum=8'h10, co=0.
6. **Exhaustive sweep.** With WIDTH=4, run all 512 combinations of (a, b, ci) back-to-back. Required: at every done, {co, sum} == a+b+ci, and every done arrives exactly 5 edges after its start.
